usb_tx_scheduler: RTL and testbench

//  Arbitrates three USB transmit requesters (handshake response, start/data packet, empty packet).

---
 rtl/usb_tx_scheduler.sv | 247 ++++++++++++++++++++++++
 tb/tb_usb_tx_scheduler.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/usb_tx_scheduler.sv
// usb_tx_scheduler: picks one of three transmit requesters and walks the packet
// through launch, word shifting, EOP (SE0 then J) and the inter-packet gap.
module usb_tx_scheduler #(
  parameter int unsigned CLKS_PER_BIT = 8,
  parameter int unsigned EOP_SE0_BITS = 2,
  parameter int unsigned GAP_BITS     = 2
) (
  input  logic       clk_i,
  input  logic       n_rst_i,
  input  logic       req_response_i,
  input  logic       req_start_i,
  input  logic       req_empty_i,
  input  logic       abort_i,
  input  logic       byte_sent_i,
  input  logic       data_sent_i,
  output logic       transmitting_o,
  output logic       transmit_response_o,
  output logic       transmit_start_o,
  output logic       transmit_empty_o,
  output logic [1:0] grant_o,
  output logic       load_word_o,
  output logic       eop_se0_o,
  output logic       eop_j_o,
  output logic       tx_busy_o,
  output logic       tx_done_o,
  output logic       tx_abort_o
);

  localparam int unsigned SE0_CYCLES = EOP_SE0_BITS * CLKS_PER_BIT;
  localparam int unsigned J_CYCLES   = CLKS_PER_BIT;
  localparam int unsigned GAP_CYCLES = GAP_BITS * CLKS_PER_BIT;
  localparam int unsigned MAX_CYCLES = (SE0_CYCLES > GAP_CYCLES) ? SE0_CYCLES : GAP_CYCLES;
  localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

  localparam logic [CNT_W-1:0] SE0_LOAD = CNT_W'(SE0_CYCLES - 1);
  localparam logic [CNT_W-1:0] J_LOAD   = CNT_W'(J_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LAUNCH  = 3'd1,
    ST_SEND    = 3'd2,
    ST_EOP_SE0 = 3'd3,
    ST_EOP_J   = 3'd4,
    ST_GAP     = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    GNT_NONE     = 2'd0,
    GNT_RESPONSE = 2'd1,
    GNT_START    = 2'd2,
    GNT_EMPTY    = 2'd3
  } grant_e;

  state_e           state_q, state_d;
  grant_e           grant_q, grant_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rr_last_q, rr_last_d;
  logic             aborted_q, aborted_d;
  logic             abort_hit_s;
  logic             done_s;

  logic transmitting_q, eop_se0_q, eop_j_q, tx_busy_q, tx_done_q, tx_abort_q;

  // Next-state, arbitration and duration-counter logic.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    cnt_d       = cnt_q;
    rr_last_d   = rr_last_q;
    aborted_d   = aborted_q;
    abort_hit_s = 1'b0;
    done_s      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        aborted_d = 1'b0;
        if (req_response_i) begin
          grant_d = GNT_RESPONSE;
          state_d = ST_LAUNCH;
        end else if (req_start_i && req_empty_i) begin
          // rr_last_q=1 means start won the last start/empty contest.
          if (rr_last_q) begin
            grant_d   = GNT_EMPTY;
            rr_last_d = 1'b0;
          end else begin
            grant_d   = GNT_START;
            rr_last_d = 1'b1;
          end
          state_d = ST_LAUNCH;
        end else if (req_start_i) begin
          grant_d   = GNT_START;
          rr_last_d = 1'b1;
          state_d   = ST_LAUNCH;
        end else if (req_empty_i) begin
          grant_d   = GNT_EMPTY;
          rr_last_d = 1'b0;
          state_d   = ST_LAUNCH;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LAUNCH, ST_SEND: begin
        if (abort_i) begin
          abort_hit_s = 1'b1;
          aborted_d   = 1'b1;
          state_d     = ST_EOP_SE0;
          cnt_d       = SE0_LOAD;
        end else if ((state_q == ST_SEND) && data_sent_i) begin
          state_d = ST_EOP_SE0;
          cnt_d   = SE0_LOAD;
        end else begin
          state_d = ST_SEND;
        end
      end
      ST_EOP_SE0: begin
        if (cnt_q == CNT_ZERO) begin
          state_d = ST_EOP_J;
          cnt_d   = J_LOAD;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      ST_EOP_J: begin
        if (cnt_q == CNT_ZERO) begin
          state_d = ST_GAP;
          cnt_d   = GAP_LOAD;
          done_s  = ~aborted_q;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      ST_GAP: begin
        if (cnt_q == CNT_ZERO) begin
          state_d = ST_IDLE;
          grant_d = GNT_NONE;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = GNT_NONE;
        cnt_d   = CNT_ZERO;
      end
    endcase
  end

  // State, arbitration memory and registered drive outputs.
  always_ff @(posedge clk_i or negedge n_rst_i) begin
    if (!n_rst_i) begin
      state_q        <= ST_IDLE;
      grant_q        <= GNT_NONE;
      cnt_q          <= CNT_ZERO;
      rr_last_q      <= 1'b0;
      aborted_q      <= 1'b0;
      transmitting_q <= 1'b0;
      eop_se0_q      <= 1'b0;
      eop_j_q        <= 1'b0;
      tx_busy_q      <= 1'b0;
      tx_done_q      <= 1'b0;
      tx_abort_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      grant_q        <= grant_d;
      cnt_q          <= cnt_d;
      rr_last_q      <= rr_last_d;
      aborted_q      <= aborted_d;
      transmitting_q <= (state_d == ST_LAUNCH) || (state_d == ST_SEND);
      eop_se0_q      <= (state_d == ST_EOP_SE0);
      eop_j_q        <= (state_d == ST_EOP_J);
      tx_busy_q      <= (state_d != ST_IDLE);
      tx_done_q      <= done_s;
      tx_abort_q     <= abort_hit_s;
    end
  end

  // Timer-facing strobes decoded from state and the same-cycle timer pulses.
  always_comb begin
    load_word_o         = 1'b0;
    transmit_response_o = 1'b0;
    transmit_start_o    = 1'b0;
    transmit_empty_o    = 1'b0;
    if (state_q == ST_LAUNCH) begin
      load_word_o         = 1'b1;
      transmit_response_o = (grant_q == GNT_RESPONSE);
      transmit_start_o    = (grant_q == GNT_START);
      transmit_empty_o    = (grant_q == GNT_EMPTY);
    end else if (state_q == ST_SEND) begin
      // A word loaded in an aborting cycle would never be shifted out.
      load_word_o = byte_sent_i & ~data_sent_i & ~abort_i;
    end else begin
      load_word_o = 1'b0;
    end
  end

  assign transmitting_o = transmitting_q;
  assign grant_o        = grant_q;
  assign eop_se0_o      = eop_se0_q;
  assign eop_j_o        = eop_j_q;
  assign tx_busy_o      = tx_busy_q;
  assign tx_done_o      = tx_done_q;
  assign tx_abort_o     = tx_abort_q;

  usb_tx_scheduler_chk u_chk (
    .clk_i               (clk_i),
    .n_rst_i             (n_rst_i),
    .transmitting_i      (transmitting_q),
    .transmit_response_i (transmit_response_o),
    .transmit_start_i    (transmit_start_o),
    .transmit_empty_i    (transmit_empty_o),
    .eop_se0_i           (eop_se0_q),
    .eop_j_i             (eop_j_q),
    .tx_done_i           (tx_done_q),
    .tx_abort_i          (tx_abort_q)
  );

endmodule

// Structural invariants of the scheduler outputs.
module usb_tx_scheduler_chk (
  input logic clk_i,
  input logic n_rst_i,
  input logic transmitting_i,
  input logic transmit_response_i,
  input logic transmit_start_i,
  input logic transmit_empty_i,
  input logic eop_se0_i,
  input logic eop_j_i,
  input logic tx_done_i,
  input logic tx_abort_i
);

  a_one_strobe: assert property (@(posedge clk_i) disable iff (!n_rst_i)
    $onehot0({transmit_response_i, transmit_start_i, transmit_empty_i}));

  a_eop_exclusive: assert property (@(posedge clk_i) disable iff (!n_rst_i)
    !(eop_se0_i && eop_j_i));

  a_no_tx_in_eop: assert property (@(posedge clk_i) disable iff (!n_rst_i)
    !(transmitting_i && (eop_se0_i || eop_j_i)));

  a_done_xor_abort: assert property (@(posedge clk_i) disable iff (!n_rst_i)
    !(tx_done_i && tx_abort_i));

endmodule

// File: tb/tb_usb_tx_scheduler.sv
// Directed and randomized packets for usb_tx_scheduler, checked against a
// packet-level timing model (grant rules, pulse counts, EOP/GAP cycle offsets).
module tb_usb_tx_scheduler;

  localparam int SE0_CYC = 16;
  localparam int J_CYC   = 8;
  localparam int GAP_CYC = 16;

  logic clk = 1'b0;
  logic n_rst, req_response, req_start, req_empty, abort, byte_sent, data_sent;
  logic transmitting, transmit_response, transmit_start, transmit_empty;
  logic [1:0] grant;
  logic load_word, eop_se0, eop_j, tx_busy, tx_done, tx_abort;

  int n_checks = 0;
  int n_fail   = 0;
  int m_last_sa = 3;  // last start/empty winner; 3 => start wins the next tie

  always #5 clk = ~clk;

  usb_tx_scheduler dut (
    .clk_i               (clk),
    .n_rst_i             (n_rst),
    .req_response_i      (req_response),
    .req_start_i         (req_start),
    .req_empty_i         (req_empty),
    .abort_i             (abort),
    .byte_sent_i         (byte_sent),
    .data_sent_i         (data_sent),
    .transmitting_o      (transmitting),
    .transmit_response_o (transmit_response),
    .transmit_start_o    (transmit_start),
    .transmit_empty_o    (transmit_empty),
    .grant_o             (grant),
    .load_word_o         (load_word),
    .eop_se0_o           (eop_se0),
    .eop_j_o             (eop_j),
    .tx_busy_o           (tx_busy),
    .tx_done_o           (tx_done),
    .tx_abort_o          (tx_abort)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int mon_load = 0, mon_tr = 0, mon_ts = 0, mon_te = 0, mon_tx = 0;
  int mon_se0 = 0, mon_j = 0, mon_done = 0, mon_abt = 0;
  int se0_rise = -1, done_at = -1, abt_at = -1;
  logic prev_se0 = 1'b0;

  always @(negedge clk) begin
    if (load_word)         mon_load <= mon_load + 1;
    if (transmit_response) mon_tr   <= mon_tr + 1;
    if (transmit_start)    mon_ts   <= mon_ts + 1;
    if (transmit_empty)    mon_te   <= mon_te + 1;
    if (transmitting)      mon_tx   <= mon_tx + 1;
    if (eop_se0)           mon_se0  <= mon_se0 + 1;
    if (eop_j)             mon_j    <= mon_j + 1;
    if (tx_done) begin
      mon_done <= mon_done + 1;
      done_at  <= cyc;
    end
    if (tx_abort) begin
      mon_abt <= mon_abt + 1;
      abt_at  <= cyc;
    end
    if (eop_se0 && !prev_se0) se0_rise <= cyc;
    prev_se0 <= eop_se0;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [1:0] model_grant(input logic r, input logic s, input logic e);
    int w;
    if (r) return 2'd1;
    if (s && e) w = (m_last_sa == 2) ? 3 : 2;
    else if (s) w = 2;
    else        w = 3;
    m_last_sa = w;
    return w[1:0];
  endfunction

  // One packet: requests in IDLE, data_sent 'period*nwords' clocks after LAUNCH,
  // byte_sent every 'period' clocks, optional abort at clock abort_k after LAUNCH.
  task automatic run_pkt(input logic r, input logic s, input logic e, input int period,
                         input int nwords, input int abort_k, input bit bs_on_last, input bit hold);
    int d, stop, e0, x, exp_str, obs_str;
    int b_load, b_tr, b_ts, b_te, b_tx, b_se0, b_j, b_done, b_abt;
    logic [1:0] g;
    bit aborted;
    g = model_grant(r, s, e);
    d = period * nwords;
    aborted = (abort_k > 0);
    stop = aborted ? abort_k : d;
    b_load = mon_load; b_tr = mon_tr; b_ts = mon_ts; b_te = mon_te; b_tx = mon_tx;
    b_se0 = mon_se0; b_j = mon_j; b_done = mon_done; b_abt = mon_abt;
    req_response = r; req_start = s; req_empty = e;
    tick();
    e0 = cyc;
    chk("grant_launch", grant, g);
    chk("busy_launch", tx_busy, 1);
    if (!hold) begin
      req_response = 1'b0; req_start = 1'b0; req_empty = 1'b0;
    end
    for (int k = 1; k <= stop; k++) begin
      byte_sent = ((k % period) == 0) && ((k < stop) || ((k == d) && bs_on_last));
      data_sent = (k == d);
      abort     = (k == abort_k);
      tick();
    end
    byte_sent = 1'b0; data_sent = 1'b0; abort = 1'b0;
    x = e0 + stop;
    chk("tx_low_after_end", transmitting, 0);
    repeat (SE0_CYC + J_CYC + GAP_CYC - 1) tick();
    chk("busy_gap_last", tx_busy, 1);
    chk("grant_gap_last", grant, g);
    tick();
    chk("busy_idle", tx_busy, 0);
    chk("grant_idle", grant, 0);
    exp_str = (g == 2'd1) ? 100 : (g == 2'd2) ? 10 : 1;
    obs_str = (mon_tr - b_tr) * 100 + (mon_ts - b_ts) * 10 + (mon_te - b_te);
    chk("type_strobe", obs_str, exp_str);
    chk("load_words", mon_load - b_load, 1 + (stop - 1) / period);
    chk("tx_cycles", mon_tx - b_tx, stop);
    chk("se0_start", se0_rise, x);
    chk("se0_cycles", mon_se0 - b_se0, SE0_CYC);
    chk("j_cycles", mon_j - b_j, J_CYC);
    chk("done_count", mon_done - b_done, aborted ? 0 : 1);
    chk("abort_count", mon_abt - b_abt, aborted ? 1 : 0);
    if (aborted) chk("abort_cycle", abt_at, x);
    else         chk("done_cycle", done_at, x + SE0_CYC + J_CYC);
  endtask

  initial begin
    logic [2:0] v;
    int per, nw, ak;
    n_rst = 1'b0; req_response = 1'b0; req_start = 1'b0; req_empty = 1'b0;
    abort = 1'b0; byte_sent = 1'b0; data_sent = 1'b0;
    #12;
    chk("reset_outputs", {transmitting, transmit_response, transmit_start, transmit_empty, grant,
                          load_word, eop_se0, eop_j, tx_busy, tx_done, tx_abort}, 0);
    tick();
    n_rst = 1'b1;
    tick();
    chk("idle_after_reset", {tx_busy, grant, transmitting}, 0);

    // Asynchronous reset in the middle of SEND.
    req_start = 1'b1;
    tick();
    req_start = 1'b0;
    repeat (10) tick();
    chk("tx_before_reset", {transmitting, tx_busy, grant}, 32'h0000_000E);
    #2 n_rst = 1'b0;
    #1;
    chk("async_reset_clears", {transmitting, eop_se0, grant, tx_busy}, 0);
    tick();
    #2 n_rst = 1'b1;
    tick();
    m_last_sa = 3;
    chk("idle_after_mid_reset", {tx_busy, grant, transmitting, eop_se0}, 0);

    run_pkt(1'b1, 1'b0, 1'b0, 128, 1, 0, 1'b0, 1'b0);
    repeat (4) run_pkt(1'b0, 1'b1, 1'b1, 16, 1, 0, 1'b0, 1'b1);
    run_pkt(1'b1, 1'b1, 1'b1, 16, 1, 0, 1'b0, 1'b0);
    run_pkt(1'b0, 1'b0, 1'b1, 128, 3, 0, 1'b1, 1'b0);
    run_pkt(1'b0, 1'b1, 1'b0, 128, 2, 50, 1'b0, 1'b0);
    run_pkt(1'b0, 1'b1, 1'b0, 32, 2, 64, 1'b1, 1'b1);
    run_pkt(1'b0, 1'b1, 1'b0, 16, 1, 0, 1'b0, 1'b0);
    run_pkt(1'b1, 1'b0, 1'b0, 16, 2, 1, 1'b0, 1'b0);

    for (int i = 0; i < 20; i++) begin
      repeat ($urandom_range(0, 2)) tick();
      v   = 3'($urandom_range(1, 7));
      per = $urandom_range(8, 24);
      nw  = $urandom_range(1, 4);
      ak  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, per * nw) : 0;
      run_pkt(v[2], v[1], v[0], per, nw, ak, 1'($urandom_range(0, 1)), 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
